// File: rtl/iob_ram_2p_sync.sv
module iob_ram_2p_sync #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned ADDR_W        = 4,
  parameter string       MEM_INIT_FILE = "none"
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              w_en_i,
  input  logic [ADDR_W-1:0] w_addr_i,
  input  logic [DATA_W-1:0] w_data_i,
  input  logic              r_en_i,
  input  logic [ADDR_W-1:0] r_addr_i,
  output logic [DATA_W-1:0] r_data_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] r_data_q = '0;
  logic [DATA_W-1:0] r_data_d;

  always_ff @(posedge clk_i) begin
    if (w_en_i) begin
      mem[w_addr_i] <= w_data_i;
    end
  end

  always_comb begin
    r_data_d = r_data_q;
    if (r_en_i) begin
      r_data_d = mem[r_addr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data_q <= '0;
    end else begin
      r_data_q <= r_data_d;
    end
  end

  assign r_data_o = r_data_q;

endmodule

// File: tb/tb_iob_ram_2p_sync.sv
// Directed bench for iob_ram_2p_sync with DATA_W=8, ADDR_W=4.
module tb_iob_ram_2p_sync;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              w_en;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              r_en;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    int checks   = 0;
    int failures = 0;

    iob_ram_2p_sync #(
        .DATA_W       (DATA_W),
        .ADDR_W       (ADDR_W),
        .MEM_INIT_FILE("none")
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .w_en_i  (w_en),
        .w_addr_i(w_addr),
        .w_data_i(w_data),
        .r_en_i  (r_en),
        .r_addr_i(r_addr),
        .r_data_o(r_data)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DATA_W-1:0] expected);
        checks++;
        assert (r_data === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, r_data, expected);
        end
    endtask

    initial begin
        rst    = 1'b0;
        w_en   = 1'b0;
        w_addr = '0;
        w_data = '0;
        r_en   = 1'b0;
        r_addr = '0;
        #1;
        check("powerup", 8'h00);

        // Fill: address i gets i+32.
        for (int i = 0; i < 16; i++) begin
            w_en   = 1'b1;
            w_addr = ADDR_W'(i);
            w_data = DATA_W'(i + 32);
            step();
        end
        w_en = 1'b0;

        // Disabled read, no reset ever applied: output stays at power-up 0.
        for (int i = 0; i < 16; i++) begin
            r_addr = ADDR_W'(i);
            step();
            check("disabled_read", 8'h00);
        end

        // Enabled read sweep.
        r_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            r_addr = ADDR_W'(i);
            step();
            check("enabled_read", DATA_W'(i + 32));
        end

        // Hold: read 5, then drop enable and move the address.
        r_addr = 4'd5;
        step();
        check("hold_read5", 8'd37);
        r_en   = 1'b0;
        r_addr = 4'd9;
        step();
        check("hold_1", 8'd37);
        step();
        check("hold_2", 8'd37);

        // Read-first collision on address 3.
        w_en   = 1'b1;
        w_addr = 4'd3;
        w_data = 8'hAA;
        r_en   = 1'b1;
        r_addr = 4'd3;
        step();
        check("collision_old", 8'd35);
        w_en = 1'b0;
        step();
        check("collision_new", 8'hAA);

        // Write latency: write at edge N, read issued at edge N+1.
        w_en   = 1'b1;
        w_addr = 4'd12;
        w_data = 8'h77;
        r_addr = 4'd0;
        step();
        check("wlat_other", 8'd32);
        w_en   = 1'b0;
        r_addr = 4'd12;
        step();
        check("wlat_read", 8'h77);

        // Reset overrides an enabled read; a write during reset still lands.
        rst    = 1'b1;
        r_en   = 1'b1;
        r_addr = 4'd7;
        w_en   = 1'b1;
        w_addr = 4'd10;
        w_data = 8'h5C;
        step();
        check("reset_clear", 8'h00);
        w_en = 1'b0;
        step();
        check("reset_hold", 8'h00);
        rst = 1'b0;
        step();
        check("post_reset_read7", 8'd39);
        r_addr = 4'd10;
        step();
        check("write_during_reset", 8'h5C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
